// File: rtl/tof_i2c_master.sv
// tof_i2c_master: I2C master issuing 16-bit-register byte writes and reads to a ToF sensor.
module tof_i2c_master #(
  parameter logic [6:0] DEV_ADDR = 7'h29,
  parameter int CLK_DIV = 125
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        is_read,
  input  logic [15:0] register_address,
  input  logic [7:0]  i2c_data,
  output logic        ready,
  output logic        error_out,
  output logic [15:0] i2c_data_in,
  output logic        scl,
  output logic        sda_oe,
  input  logic        sda_in
);
  typedef enum logic [3:0] {IDLE, START, SEND_BYTE, GET_ACK, RSTART, RECV_BYTE, SEND_NACK, STOP, DONE} state_t;
  state_t state, n_state;
  logic [9:0] div;
  logic [1:0] phase, n_phase;
  logic [2:0] bit_cnt, n_bit, byte_idx, n_idx;
  logic [15:0] addr;
  logic [7:0] data, rx, tx;
  logic rd, nack, busy, tick, slot_end, n_scl, n_oe;
  always_comb begin
    busy = state != IDLE && state != DONE;
    tick = busy && div == 10'd0;
    slot_end = tick && phase == 2'd3;
    n_state = state;
    n_phase = tick ? phase + 2'd1 : phase;
    n_bit = bit_cnt;
    n_idx = byte_idx;
    if (state == IDLE && start && !ready) begin
      n_state = START;
      n_phase = 2'd0;
      n_bit = 3'd0;
      n_idx = 3'd0;
    end
    if (state == DONE && !start) n_state = IDLE;
    if (slot_end)
      case (state)
        START:     n_state = SEND_BYTE;
        SEND_BYTE: begin
          n_bit = bit_cnt + 3'd1;
          n_state = bit_cnt == 3'd7 ? GET_ACK : SEND_BYTE;
        end
        GET_ACK:   begin
          n_idx = byte_idx + 3'd1;
          n_state = nack ? STOP : byte_idx == 3'd3 ? (rd ? RECV_BYTE : STOP) :
                    (byte_idx == 3'd2 && rd) ? RSTART : SEND_BYTE;
        end
        RSTART:    n_state = START;
        RECV_BYTE: begin
          n_bit = bit_cnt + 3'd1;
          n_state = bit_cnt == 3'd7 ? SEND_NACK : RECV_BYTE;
        end
        SEND_NACK: n_state = STOP;
        STOP:      n_state = DONE;
        default:   n_state = state;
      endcase
    tx = n_idx == 3'd0 ? {DEV_ADDR, 1'b0} : n_idx == 3'd1 ? addr[15:8] :
         n_idx == 3'd2 ? addr[7:0] : rd ? {DEV_ADDR, 1'b1} : data;
    // START/STOP move SDA while SCL is high; every other slot is low-low-high-high
    n_scl = (n_state inside {IDLE, DONE, START}) ? 1'b1 : n_state == STOP ? n_phase != 2'd0 : n_phase[1];
    n_oe = n_state == START ? n_phase[1] : n_state == STOP ? !n_phase[1] :
           n_state == SEND_BYTE ? !tx[3'd7 - n_bit] : 1'b0;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      div <= 10'(CLK_DIV - 1);
      phase <= 2'd0;
      bit_cnt <= 3'd0;
      byte_idx <= 3'd0;
      scl <= 1'b1;
      sda_oe <= 1'b0;
      ready <= 1'b0;
      error_out <= 1'b0;
      i2c_data_in <= 16'h0000;
      nack <= 1'b0;
    end else begin
      state <= n_state;
      phase <= n_phase;
      bit_cnt <= n_bit;
      byte_idx <= n_idx;
      scl <= n_scl;
      sda_oe <= n_oe;
      div <= (!busy || tick) ? 10'(CLK_DIV - 1) : div - 10'd1;
      ready <= n_state == DONE;
      if (state == IDLE && n_state == START) begin
        rd <= is_read;
        addr <= register_address;
        data <= i2c_data;
        error_out <= 1'b0;
      end
      if (tick && phase == 2'd2) begin
        nack <= sda_in;
        rx <= state == RECV_BYTE ? {rx[6:0], sda_in} : rx;
      end
      if (slot_end && state == GET_ACK && nack) error_out <= 1'b1;
      if (state == STOP && n_state == DONE && rd && !error_out) i2c_data_in <= {8'h00, rx};
    end
  end
endmodule

// File: tb/tb_tof_i2c_master.sv
// tb_tof_i2c_master: bus-decoding slave model and transaction-level reference for tof_i2c_master.
module tb_tof_i2c_master;
  localparam int D = 4;
  localparam logic [6:0] DEV = 7'h29;
  logic clk = 0, reset = 1, start = 0, is_read = 0, tstart = 0;
  logic [15:0] register_address = 0;
  logic [7:0] i2c_data = 0;
  logic ready, error_out, scl, sda_oe, sda_in;
  logic [15:0] i2c_data_in;
  logic t2_rdy, t2_err, t2_scl, t2_oe, t9_rdy, t9_err, t9_scl, t9_oe;
  logic [15:0] t2_dat, t9_dat;
  logic slave_low = 0;
  int n_chk = 0, n_pass = 0, n_fail = 0;
  int ev[$], exp_q[$];
  int gcnt = 0, nack_at = 99, bp = 0, bcnt = 0;
  logic [7:0] s_rdat = 0;
  logic [8:0] sh = 0;
  logic psc = 1, psd = 1, line_v;
  bit reading = 0;
  logic [15:0] exp_dat = 0;
  int last_lat = 0;
  int t2_lo[$], t2_hi[$], t9_lo[$], t9_hi[$];
  int t2_run = 0, t9_run = 0;
  logic t2_p = 1, t9_p = 1;

  always #5 clk = ~clk;
  assign sda_in = !sda_oe && !slave_low;

  tof_i2c_master #(.DEV_ADDR(DEV), .CLK_DIV(D)) dut (
    .clk(clk), .reset(reset), .start(start), .is_read(is_read),
    .register_address(register_address), .i2c_data(i2c_data),
    .ready(ready), .error_out(error_out), .i2c_data_in(i2c_data_in),
    .scl(scl), .sda_oe(sda_oe), .sda_in(sda_in));
  tof_i2c_master #(.CLK_DIV(2)) u_t2 (
    .clk(clk), .reset(reset), .start(tstart), .is_read(1'b0),
    .register_address(16'h1234), .i2c_data(8'h5A),
    .ready(t2_rdy), .error_out(t2_err), .i2c_data_in(t2_dat),
    .scl(t2_scl), .sda_oe(t2_oe), .sda_in(1'b0));
  tof_i2c_master #(.CLK_DIV(125)) u_t9 (
    .clk(clk), .reset(reset), .start(tstart), .is_read(1'b0),
    .register_address(16'h1234), .i2c_data(8'h5A),
    .ready(t9_rdy), .error_out(t9_err), .i2c_data_in(t9_dat),
    .scl(t9_scl), .sda_oe(t9_oe), .sda_in(1'b0));

  // SCL pulse widths in clk cycles, as seen mid-cycle
  always @(negedge clk) begin
    if (reset) begin
      t2_run = 0; t2_p = 1; t9_run = 0; t9_p = 1;
    end else begin
      if (t2_scl === t2_p) t2_run++;
      else begin
        if (t2_p) t2_hi.push_back(t2_run); else t2_lo.push_back(t2_run);
        t2_run = 1; t2_p = t2_scl;
      end
      if (t9_scl === t9_p) t9_run++;
      else begin
        if (t9_p) t9_hi.push_back(t9_run); else t9_lo.push_back(t9_run);
        t9_run = 1; t9_p = t9_scl;
      end
    end
  end

  // Slave + bus decoder: events are -1 START, -2 STOP, else {ack, byte}
  always @(negedge clk) begin
    if (reset) begin
      psc = 1; psd = 1; bp = 0; reading = 0; slave_low = 0;
    end else begin
      line_v = !sda_oe && !slave_low;
      if (scl && psc && psd && !line_v) begin
        ev.push_back(-1); bp = 0; bcnt = 0; reading = 0;
      end else if (scl && psc && !psd && line_v) ev.push_back(-2);
      else if (scl && !psc) begin
        sh = {sh[7:0], line_v};
        bp++;
        if (bp == 9) begin
          ev.push_back(int'({sh[0], sh[8:1]}));
          if (reading) reading = 0;
          else if (bcnt == 0 && sh[1] && !sh[0]) reading = 1;
          bcnt++; gcnt++; bp = 0;
        end
      end else if (!scl && psc)
        slave_low = reading ? (bp < 8 && !s_rdat[7 - bp]) : (bp == 8 && gcnt != nack_at);
      psc = scl; psd = line_v;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  function automatic void build(input bit rd, input logic [15:0] a, input logic [7:0] d,
                                input logic [7:0] r, input int nk);
    logic [7:0] tx[4];
    tx = '{{DEV, 1'b0}, a[15:8], a[7:0], rd ? {DEV, 1'b1} : d};
    exp_q = {};
    exp_q.push_back(-1);
    for (int i = 0; i < 4; i++) begin
      if (rd && i == 3) exp_q.push_back(-1);
      exp_q.push_back((i == nk ? 256 : 0) + int'(tx[i]));
      if (i == nk) begin
        exp_q.push_back(-2);
        return;
      end
    end
    if (rd) exp_q.push_back(256 + int'(r));
    exp_q.push_back(-2);
  endfunction

  task automatic run(input bit rd, input logic [15:0] a, input logic [7:0] d, input logic [7:0] r,
                     input int nk, input string tag, input bit hold);
    int cyc;
    s_rdat = r; nack_at = nk; gcnt = 0; ev = {};
    build(rd, a, d, r, nk);
    is_read = rd; register_address = a; i2c_data = d; start = 1;
    step();
    cyc = 1;
    is_read = ~rd; register_address = 16'($urandom); i2c_data = 8'($urandom);
    while (!ready && cyc < 3000) begin step(); cyc++; end
    last_lat = cyc;
    chk({tag, " ready"}, ready, 1);
    chk({tag, " error"}, error_out, nk < 4);
    if (rd && nk >= 4) exp_dat = {8'h00, r};
    chk({tag, " rdata"}, i2c_data_in, exp_dat);
    chk({tag, " events"}, ev.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < ev.size(); i++)
      chk($sformatf("%s ev%0d", tag, i), ev[i], exp_q[i]);
    if (!hold) begin
      start = 0;
      step();
      chk({tag, " ready drop"}, ready, 0);
    end
  endtask

  initial begin
    int cyc, bad;
    repeat (3) step();
    chk("rst scl", scl, 1);
    chk("rst sda_oe", sda_oe, 0);
    chk("rst ready", ready, 0);
    chk("rst error", error_out, 0);
    chk("rst rdata", i2c_data_in, 16'h0000);
    reset = 0;
    step();
    tstart = 1;
    cyc = 0;
    while (!t9_rdy && cyc < 25000) begin step(); cyc++; end
    chk("t125 ready", t9_rdy, 1);
    chk("t2 ready", t2_rdy, 1);
    chk("t2 lo", t2_lo.size() > 1 ? t2_lo[1] : -1, 4);
    chk("t2 hi", t2_hi.size() > 2 ? t2_hi[2] : -1, 4);
    chk("t125 lo", t9_lo.size() > 1 ? t9_lo[1] : -1, 250);
    chk("t125 hi", t9_hi.size() > 2 ? t9_hi[2] : -1, 250);
    chk("t idle lines", {t2_oe, t9_oe, t2_scl, t9_scl, t2_err, t9_err}, 6'b001100);
    chk("t wr data", {t2_dat, t9_dat}, 32'h0);
    tstart = 0;
    step();
    run(0, 16'h7FFF, 8'h00, 8'h00, 99, "write", 0);
    chk("write latency lo", last_lat >= 36 * 4 * D, 1);
    chk("write latency hi", last_lat <= 42 * 4 * D, 1);
    run(1, 16'h0000, 8'h00, 8'hF0, 99, "read", 0);
    run(0, 16'($urandom), 8'($urandom), 8'h00, 0, "addr nack", 0);
    run(0, 16'h0102, 8'h33, 8'h00, 99, "handshake", 1);
    bad = 0;
    repeat (100) begin step(); if (ready !== 1'b1) bad++; end
    chk("hs ready held", bad, 0);
    chk("hs no restart", ev.size(), exp_q.size());
    start = 0;
    step();
    chk("hs ready drop", ready, 0);
    run(1, 16'h4455, 8'h00, 8'h3C, 99, "hs restart", 0);
    s_rdat = 0; nack_at = 99; gcnt = 0; ev = {};
    is_read = 0; register_address = 16'hABCD; i2c_data = 8'h11; start = 1;
    cyc = 0;
    while (gcnt < 1 && cyc < 3000) begin step(); cyc++; end
    repeat (3 * 4 * D) step();
    chk("mr in byte2", gcnt, 1);
    reset = 1; start = 0;
    step();
    chk("mr scl", scl, 1);
    chk("mr sda_oe", sda_oe, 0);
    chk("mr ready", ready, 0);
    reset = 0;
    exp_dat = 16'h0000;
    step();
    run(0, 16'hABCD, 8'h11, 8'h00, 99, "after reset", 0);
    for (int k = 0; k < 6; k++)
      run(1'($urandom_range(0, 1)), 16'($urandom), 8'($urandom), 8'($urandom),
          int'($urandom_range(0, 9)), $sformatf("rnd%0d", k), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
